// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline control slice.
// Contents: register-file sizing, controller state encoding, and a one-hot helper.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1,
    StDrain = 2'd2,
    StHalt  = 2'd3
  } ctrl_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: one pending bit per architectural register.
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   clr_valid/clr_addr  writeback retiring a register write (clears a bit)
//   set_valid/set_addr  issued instruction that will write a register (sets a bit)
//   busy_mask           registered pending-write mask (bit 0 always 0)
//   eff_mask            busy_mask with the same-cycle writeback already removed
module reg_scoreboard
  import core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic [NUM_REGS-1:0]   eff_mask
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;

  // Kept as separate assigns so eff_mask never appears to depend on set_valid.
  assign clr_vec  = clr_valid ? reg_onehot(clr_addr) : '0;
  assign eff_mask = busy_q & ~clr_vec;

  always_comb begin
    set_vec = '0;
    if (set_valid && (set_addr != '0)) begin
      set_vec = reg_onehot(set_addr);
    end
  end

  // Set is OR-ed after the clear so a same-cycle set on the same register wins.
  always_comb begin
    busy_d    = eff_mask | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode/execute sequencing controller: scoreboard-based RAW/WAW stalls, decode flush
// after redirects, FENCE drain and ECALL/EBREAK halt.
// Ports:
//   clk, rst                    core clock, synchronous active-high reset
//   dec_*                       decoded instruction fields and class flags
//   redirect                    taken branch/jump reported by execute
//   wb_valid/wb_rd              writeback retiring a register write
//   mem_busy                    load/store unit has an access outstanding
//   resume                      leave halt
//   issue, stall, flush, halted combinational control outputs
//   busy_mask                   registered scoreboard
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned FLUSH_CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_uses_rs1,
  input  logic                  dec_uses_rs2,
  input  logic                  dec_writes_rd,
  input  logic                  dec_fence,
  input  logic                  dec_system,
  input  logic                  redirect,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_busy,
  input  logic                  resume,
  output logic                  issue,
  output logic                  stall,
  output logic                  flush,
  output logic                  halted,
  output logic [NUM_REGS-1:0]   busy_mask
);

  localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_W-1:0] CntOne    = FLUSH_CNT_W'(1);

  ctrl_state_e            state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0]    eff_mask;
  logic                   hazard;
  logic                   drained;
  logic                   fence_req;
  logic                   system_req;

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clr_valid (wb_valid),
    .clr_addr  (wb_rd),
    .set_valid (issue & dec_writes_rd),
    .set_addr  (dec_rd),
    .busy_mask (busy_mask),
    .eff_mask  (eff_mask)
  );

  // eff_mask already has the same-cycle writeback removed, giving the bypass.
  assign hazard = dec_valid & ((dec_uses_rs1  & eff_mask[dec_rs1]) |
                               (dec_uses_rs2  & eff_mask[dec_rs2]) |
                               (dec_writes_rd & eff_mask[dec_rd]));

  assign drained    = (eff_mask == '0) & ~mem_busy;
  assign fence_req  = dec_valid & dec_fence;
  assign system_req = dec_valid & dec_system;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redirect) begin
          state_d = StFlush;
          cnt_d   = FlushLoad;
        end else if (fence_req) begin
          // Hold the FENCE in decode until the pipeline has drained.
          stall   = 1'b1;
          state_d = StDrain;
        end else if (hazard) begin
          stall = 1'b1;
        end else if (system_req) begin
          // ECALL/EBREAK leaves decode as a NOP; the halt holds everything after it.
          state_d = StHalt;
        end else begin
          issue = dec_valid;
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (redirect) begin
          cnt_d = FlushLoad;
        end else if (cnt_q == CntOne) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDrain: begin
        if (redirect) begin
          state_d = StFlush;
          cnt_d   = FlushLoad;
        end else if (drained) begin
          issue   = 1'b1;
          state_d = StRun;
        end else begin
          stall = 1'b1;
        end
      end
      StHalt: begin
        halted = 1'b1;
        if (redirect) begin
          state_d = StFlush;
          cnt_d   = FlushLoad;
        end else begin
          stall = 1'b1;
          if (resume) begin
            state_d = StRun;
          end
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int FlushCycles = 2;
  localparam int MRun   = 0;
  localparam int MFlush = 1;
  localparam int MDrain = 2;
  localparam int MHalt  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_fence, dec_system;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, wb_rd;
  logic        redirect, wb_valid, mem_busy, resume;
  logic        issue, stall, flush, halted;
  logic [31:0] busy_mask;
  logic [3:0]  outs;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign outs = {issue, stall, flush, halted};

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (FlushCycles),
    .FLUSH_CNT_W  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_rd        (dec_rd),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_uses_rs1  (dec_uses_rs1),
    .dec_uses_rs2  (dec_uses_rs2),
    .dec_writes_rd (dec_writes_rd),
    .dec_fence     (dec_fence),
    .dec_system    (dec_system),
    .redirect      (redirect),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .mem_busy      (mem_busy),
    .resume        (resume),
    .issue         (issue),
    .stall         (stall),
    .flush         (flush),
    .halted        (halted),
    .busy_mask     (busy_mask)
  );

  task automatic idle_inputs();
    dec_valid = 0; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
    dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_writes_rd = 0;
    dec_fence = 0; dec_system = 0; redirect = 0;
    wb_valid = 0; wb_rd = 0; mem_busy = 0; resume = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic u1, input logic wr);
    dec_valid = v; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = 0;
    dec_uses_rs1 = u1; dec_uses_rs2 = 0; dec_writes_rd = wr;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    #3;
    tests_run++;
    if (outs !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_outs: got %b want 0000", outs);
    end
    tests_run++;
    if (busy_mask !== 32'h0) begin
      tests_failed++; $display("FAIL reset_mask: got %h want 0", busy_mask);
    end
    next_cycle();
  endtask

  task automatic test_raw_stall();
    reset_dut();
    set_dec(1, 5'd5, 5'd0, 0, 1);
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL raw_prod: got %b want 1000", outs); end
    next_cycle();
    set_dec(1, 5'd6, 5'd5, 1, 1);
    #3; tests_run++;
    if (outs !== 4'b0100) begin tests_failed++; $display("FAIL raw_stall0: got %b want 0100", outs); end
    tests_run++;
    if (busy_mask !== 32'h20) begin
      tests_failed++; $display("FAIL raw_mask0: got %h want 00000020", busy_mask);
    end
    next_cycle();
    #3; tests_run++;
    if (outs !== 4'b0100) begin tests_failed++; $display("FAIL raw_stall1: got %b want 0100", outs); end
    next_cycle();
    wb_valid = 1; wb_rd = 5'd5;
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL raw_bypass: got %b want 1000", outs); end
    next_cycle();
    idle_inputs();
    #3; tests_run++;
    if (busy_mask !== 32'h40) begin
      tests_failed++; $display("FAIL raw_mask1: got %h want 00000040", busy_mask);
    end
    next_cycle();
  endtask

  task automatic test_x0_write();
    reset_dut();
    set_dec(1, 5'd0, 5'd0, 0, 1);
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL x0_issue: got %b want 1000", outs); end
    next_cycle();
    set_dec(1, 5'd0, 5'd0, 1, 1);
    #3; tests_run++;
    if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL x0_mask: got %h want 0", busy_mask); end
    tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL x0_reader: got %b want 1000", outs); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_redirect();
    logic [3:0] want_a [4] = '{4'b0000, 4'b0010, 4'b0010, 4'b1000};
    logic [3:0] want_b [5] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    reset_dut();
    // Single redirect with a live decode instruction that issues once flush ends.
    set_dec(1, 5'd1, 5'd0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      redirect = (c == 0);
      #3; tests_run++;
      if (outs !== want_a[c]) begin
        tests_failed++; $display("FAIL redir_single_c%0d: got %b want %b", c, outs, want_a[c]);
      end
      next_cycle();
    end
    reset_dut();
    // Second redirect one cycle later extends the flush window.
    for (int c = 0; c < 5; c++) begin
      redirect = (c == 0) || (c == 1);
      #3; tests_run++;
      if (outs !== want_b[c]) begin
        tests_failed++; $display("FAIL redir_double_c%0d: got %b want %b", c, outs, want_b[c]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_fence_drain();
    reset_dut();
    set_dec(1, 5'd7, 5'd0, 0, 1);
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL fence_prod: got %b want 1000", outs); end
    next_cycle();
    set_dec(1, 5'd0, 5'd0, 0, 0);
    dec_fence = 1; mem_busy = 1;
    #3; tests_run++;
    if (outs !== 4'b0100) begin tests_failed++; $display("FAIL fence_enter: got %b want 0100", outs); end
    next_cycle();
    #3; tests_run++;
    if (outs !== 4'b0100) begin tests_failed++; $display("FAIL fence_hold: got %b want 0100", outs); end
    next_cycle();
    wb_valid = 1; wb_rd = 5'd7;
    #3; tests_run++;
    if (outs !== 4'b0100) begin tests_failed++; $display("FAIL fence_membusy: got %b want 0100", outs); end
    next_cycle();
    wb_valid = 0;
    #3; tests_run++;
    if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL fence_mask: got %h want 0", busy_mask); end
    next_cycle();
    mem_busy = 0;
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL fence_issue: got %b want 1000", outs); end
    next_cycle();
    dec_fence = 0;
    set_dec(1, 5'd2, 5'd0, 0, 1);
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL fence_run: got %b want 1000", outs); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_ecall_halt();
    reset_dut();
    set_dec(1, 5'd9, 5'd0, 0, 1);
    next_cycle();
    set_dec(1, 5'd0, 5'd0, 0, 0);
    dec_system = 1;
    #3; tests_run++;
    if (outs !== 4'b0000) begin tests_failed++; $display("FAIL ecall_nop: got %b want 0000", outs); end
    next_cycle();
    idle_inputs();
    wb_valid = 1; wb_rd = 5'd9;
    #3; tests_run++;
    if (outs !== 4'b0101) begin tests_failed++; $display("FAIL ecall_halt: got %b want 0101", outs); end
    next_cycle();
    wb_valid = 0;
    #3; tests_run++;
    if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL ecall_wbclr: got %h want 0", busy_mask); end
    resume = 1;
    #1; tests_run++;
    if (outs !== 4'b0101) begin tests_failed++; $display("FAIL ecall_resume: got %b want 0101", outs); end
    next_cycle();
    resume = 0;
    set_dec(1, 5'd1, 5'd0, 0, 1);
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL ecall_run: got %b want 1000", outs); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_set_clear_reset();
    reset_dut();
    set_dec(1, 5'd3, 5'd0, 0, 1);
    next_cycle();
    wb_valid = 1; wb_rd = 5'd3;
    #3; tests_run++;
    if (outs !== 4'b1000) begin tests_failed++; $display("FAIL sc_issue: got %b want 1000", outs); end
    next_cycle();
    idle_inputs();
    #3; tests_run++;
    if (busy_mask !== 32'h8) begin
      tests_failed++; $display("FAIL sc_setwins: got %h want 00000008", busy_mask);
    end
    redirect = 1;
    next_cycle();
    redirect = 0;
    #3; tests_run++;
    if (outs !== 4'b0010) begin tests_failed++; $display("FAIL sc_inflush: got %b want 0010", outs); end
    rst = 1;
    next_cycle();
    rst = 0; wb_valid = 1; wb_rd = 5'd3;
    #3; tests_run++;
    if (outs !== 4'b0000) begin tests_failed++; $display("FAIL sc_rst_outs: got %b want 0000", outs); end
    tests_run++;
    if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL sc_rst_mask: got %h want 0", busy_mask); end
    next_cycle();
    wb_valid = 0;
    #3; tests_run++;
    if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL sc_rst_wb: got %h want 0", busy_mask); end
    next_cycle();
  endtask

  // Reference: pending[] is the set of registers with an outstanding write, mode is the
  // controller activity, flush_left counts flush cycles still owed.
  task automatic test_random();
    bit         pending [32];
    bit         eff [32];
    int         mode;
    int         flush_left;
    bit         any_pend, hz;
    logic [3:0] want;
    logic [31:0] want_mask;
    reset_dut();
    for (int r = 0; r < 32; r++) pending[r] = 0;
    mode = MRun;
    flush_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      dec_valid     = ($urandom_range(3) != 0);
      dec_rd        = 5'($urandom_range(7));
      dec_rs1       = 5'($urandom_range(7));
      dec_rs2       = 5'($urandom_range(7));
      dec_uses_rs1  = 1'($urandom_range(1));
      dec_uses_rs2  = 1'($urandom_range(1));
      dec_writes_rd = 1'($urandom_range(1));
      dec_fence     = ($urandom_range(19) == 0);
      dec_system    = ($urandom_range(19) == 0);
      redirect      = ($urandom_range(15) == 0);
      wb_valid      = 1'($urandom_range(1));
      wb_rd         = 5'($urandom_range(7));
      mem_busy      = ($urandom_range(2) == 0);
      resume        = ($urandom_range(3) == 0);

      any_pend = 0;
      for (int r = 0; r < 32; r++) begin
        eff[r] = pending[r] && !(wb_valid && (wb_rd == 5'(r)));
        if (eff[r]) any_pend = 1;
        want_mask[r] = pending[r];
      end
      hz = dec_valid && ((dec_uses_rs1 && eff[dec_rs1]) || (dec_uses_rs2 && eff[dec_rs2]) ||
                         (dec_writes_rd && eff[dec_rd]));

      want = 4'b0000;
      if (mode == MFlush) want[1] = 1;
      if (mode == MHalt) want[0] = 1;
      #3;
      tests_run++;
      if (busy_mask !== want_mask) begin
        tests_failed++;
        $display("FAIL rand_mask cyc%0d: got %h want %h", cyc, busy_mask, want_mask);
      end

      if (redirect) begin
        mode = MFlush;
        flush_left = FlushCycles;
      end else begin
        case (mode)
          MRun: begin
            if (dec_valid && dec_fence) begin
              want[2] = 1; mode = MDrain;
            end else if (hz) begin
              want[2] = 1;
            end else if (dec_valid && dec_system) begin
              mode = MHalt;
            end else begin
              want[3] = dec_valid;
            end
          end
          MFlush: begin
            flush_left--;
            if (flush_left == 0) mode = MRun;
          end
          MDrain: begin
            if (!any_pend && !mem_busy) begin
              want[3] = 1; mode = MRun;
            end else begin
              want[2] = 1;
            end
          end
          default: begin
            want[2] = 1;
            if (resume) mode = MRun;
          end
        endcase
      end

      tests_run++;
      if (outs !== want) begin
        tests_failed++;
        $display("FAIL rand_outs cyc%0d: got %b want %b (issue,stall,flush,halted)", cyc, outs, want);
      end

      if (wb_valid) pending[wb_rd] = 0;
      if (want[3] && dec_writes_rd && (dec_rd != 0)) pending[dec_rd] = 1;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_raw_stall();
    test_x0_write();
    test_redirect();
    test_fence_drain();
    test_ecall_halt();
    test_set_clear_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the RV32I core; sits between decode and execute.
- Tracks pending register writes in a scoreboard and stalls fetch/decode on RAW/WAW hazards.
- Generates the decode-stage flush (NOP insertion) on control-flow redirects.
- Drains the pipeline for FENCE and halts on ECALL/EBREAK until software/debug resume.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (1..3)
- FLUSH_CNT_W, 2, width of the flush counter; must hold FLUSH_CYCLES

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decode stage holds a real instruction
- dec_rd  in  5  destination register
- dec_rs1  in  5  source register 1
- dec_rs2  in  5  source register 2
- dec_uses_rs1  in  1  instruction reads rs1 (R/I/S/B types)
- dec_uses_rs2  in  1  instruction reads rs2 (R/S/B types)
- dec_writes_rd  in  1  instruction writes rd (R/I-alu/load/U/J/JALR)
- dec_fence  in  1  decoded FENCE opcode
- dec_system  in  1  decoded ECALL/EBREAK opcode
- redirect  in  1  execute reports taken branch/jump this cycle
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  5  register being written back
- mem_busy  in  1  load/store unit has an outstanding access
- resume  in  1  leave HALT (debug/trap return)
- issue  out  1  decode instruction accepted into execute this cycle
- stall  out  1  hold PC and decode register
- flush  out  1  drives decoder jmp (NOP insertion)
- halted  out  1  controller in HALT
- busy_mask  out  32  scoreboard, bit n = register n pending write

Behaviour:
- Reset (sync, rst=1 at clk edge): state=RUN, busy_mask=0, flush counter=0. Outputs: issue=0, stall=0, flush=0, halted=0.
- busy_mask[0] is hardwired 0; writes to x0 are never tracked.
- Effective mask eff = busy_mask with bit wb_rd cleared when wb_valid (same-cycle writeback bypass).
- hazard = dec_valid & ((uses_rs1 & eff[rs1]) | (uses_rs2 & eff[rs2]) | (writes_rd & eff[rd])).
- Scoreboard update each cycle:
  - clear bit wb_rd if wb_valid.
  - then set bit dec_rd if issue & dec_writes_rd & rd!=0.
  - Set wins over clear for the same register in the same cycle.
- States:
  - RUN: issue = dec_valid & ~hazard & ~redirect & ~dec_fence & ~dec_system; stall = hazard.
    - redirect -> FLUSH; load counter = FLUSH_CYCLES.
    - dec_fence & ~redirect -> DRAIN (stall=1, no issue).
    - dec_system & ~redirect & ~hazard -> HALT; instruction issues as NOP, issue=0.
  - FLUSH: flush=1, issue=0, stall=0; counter decrements each cycle; exit to RUN when counter reaches 1.
    - A further redirect while in FLUSH reloads the counter.
  - DRAIN: stall=1, issue=0 until eff==0 and mem_busy=0; then issue the FENCE for one cycle and return to RUN.
    - A redirect while in DRAIN goes to FLUSH; it has priority.
  - HALT: halted=1, stall=1, issue=0; scoreboard continues clearing on writeback; resume -> RUN on the next cycle.
- Priority within a cycle: rst > redirect > HALT/DRAIN hold > hazard stall.
- flush and stall are never both 1.
- All outputs are combinational from state and inputs, except busy_mask, which is registered.
- Latency: redirect at cycle N -> flush=1 in cycles N+1..N+FLUSH_CYCLES.
- A writeback at cycle N unblocks a dependent instruction in the same cycle N via the bypass.
- Reset mid-FLUSH, DRAIN or HALT returns to RUN with an empty scoreboard; in-flight writebacks after reset are ignored if the bit is already 0. Clearing a 0 bit is harmless.

Decomposition:
- Package core_pkg: state enum (RUN, FLUSH, DRAIN, HALT), REG_ADDR_W=5, NUM_REGS=32.
- Sub-module reg_scoreboard: holds busy_mask, provides set/clear and the bypassed eff output.
- FSM, flush counter and issue/stall logic stay in the top module.

Test Plan:
- RAW stall: issue x5 (writes_rd, rd=5); next instruction uses_rs1 rs1=5 -> stall=1, issue=0 until wb_valid wb_rd=5; then issue=1 in that same cycle, busy_mask[5]=0.
- x0 write: issue rd=0 writes_rd -> busy_mask stays 0; following rs1=0 reader issues with no stall.
- Redirect with FLUSH_CYCLES=2: redirect at cycle 10 -> flush=1 in cycles 11 and 12, 0 in cycle 13, stall=0 throughout; second redirect at cycle 11 extends flush through cycle 13.
- FENCE drain: busy_mask[7]=1, mem_busy=1, dec_fence -> stall held. Writeback rd=7 then mem_busy=0 -> one issue pulse, back to RUN.
- ECALL: dec_system -> halted=1, stall=1 from next cycle; resume pulse -> halted=0, RUN next cycle; pending writeback during HALT clears its bit.
- Same-cycle set/clear and reset: wb_rd=3 with issue rd=3 -> busy_mask[3]=1. Assert rst while in FLUSH -> next cycle all outputs 0 and busy_mask=0.
